// File: rtl/cpu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cpu_pkg : shared widths and types for the 24-bit pipeline stages           |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
package cpu_pkg;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/wb_bypass_mux.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | wb_bypass_mux : one register-file read port with write-first bypass        |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module wb_bypass_mux
   import cpu_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic [DW-1:0] arr_rd,
   input  logic [AW-1:0] ra,
   input  logic          reg_we,
   input  logic [AW-1:0] wr_idx,
   input  logic [DW-1:0] wr_data,
   input  logic          zero_en,
   output logic [DW-1:0] rd
);

   logic w_wr_accepted;
   logic w_hit;

   assign w_wr_accepted = reg_we && !(zero_en && (wr_idx == '0));
   assign w_hit         = w_wr_accepted && (ra == wr_idx);

   // The hard-wired zero has priority over any bypass
   always_comb begin
      rd = arr_rd;
      if (zero_en && (ra == '0)) begin
         rd = '0;
      end else if (w_hit) begin
         rd = wr_data;
      end
   end

endmodule : wb_bypass_mux
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | writeback_regfile : writeback stage committing into the architectural RF   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module writeback_regfile #(
   parameter int DATA_W      = cpu_pkg::DATA_W,
   parameter int ADDR_W      = cpu_pkg::ADDR_W,
   parameter int NUM_REGS    = cpu_pkg::NUM_REGS,
   parameter bit ZERO_REG_EN = 1'b0,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                regWe,
   input  logic [DATA_W-1:0]   dataToWrite,
   input  logic [ADDR_W-1:0]   regToWrite,
   input  logic [ADDR_W-1:0]   ra1,
   input  logic [ADDR_W-1:0]   ra2,
   output logic [DATA_W-1:0]   rd1,
   output logic [DATA_W-1:0]   rd2,
   output logic                wbDone,
   output logic [NUM_REGS-1:0] writtenMask,
   output logic [CNT_W-1:0]    writeCount
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                wb_done_q, wb_done_d;
   logic [NUM_REGS-1:0] written_mask_q, written_mask_d;
   logic [CNT_W-1:0]    write_count_q, write_count_d;

   logic                w_commit_ok;
   logic [DATA_W-1:0]   w_arr_rd1;
   logic [DATA_W-1:0]   w_arr_rd2;

   assign w_commit_ok = regWe && !(ZERO_REG_EN && (regToWrite == '0));

   always_comb begin
      regs_d         = regs_q;
      written_mask_d = written_mask_q;
      write_count_d  = write_count_q;
      wb_done_d      = w_commit_ok;
      if (w_commit_ok) begin
         regs_d[regToWrite]         = dataToWrite;
         written_mask_d[regToWrite] = 1'b1;
         if (write_count_q != C_CNT_MAX) begin
            write_count_d = write_count_q + CNT_W'(1);
         end
      end
   end

   // Reset takes priority, so a write presented during reset is discarded
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         wb_done_q      <= 1'b0;
         written_mask_q <= '0;
         write_count_q  <= '0;
      end else begin
         regs_q         <= regs_d;
         wb_done_q      <= wb_done_d;
         written_mask_q <= written_mask_d;
         write_count_q  <= write_count_d;
      end
   end

   assign w_arr_rd1 = regs_q[ra1];
   assign w_arr_rd2 = regs_q[ra2];

   wb_bypass_mux #(
      .DW (DATA_W),
      .AW (ADDR_W)
   ) u_rd1_mux (
      .arr_rd  (w_arr_rd1),
      .ra      (ra1),
      .reg_we  (regWe),
      .wr_idx  (regToWrite),
      .wr_data (dataToWrite),
      .zero_en (ZERO_REG_EN),
      .rd      (rd1)
   );

   wb_bypass_mux #(
      .DW (DATA_W),
      .AW (ADDR_W)
   ) u_rd2_mux (
      .arr_rd  (w_arr_rd2),
      .ra      (ra2),
      .reg_we  (regWe),
      .wr_idx  (regToWrite),
      .wr_data (dataToWrite),
      .zero_en (ZERO_REG_EN),
      .rd      (rd2)
   );

   assign wbDone      = wb_done_q;
   assign writtenMask = written_mask_q;
   assign writeCount  = write_count_q;

endmodule : writeback_regfile
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_writeback_regfile : two configurations driven in lockstep               |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_writeback_regfile;

   logic        clk;
   logic        reset;
   logic        regWe;
   logic [23:0] dataToWrite;
   logic [3:0]  regToWrite;
   logic [3:0]  ra1;
   logic [3:0]  ra2;

   logic [23:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_done, b_done;
   logic [15:0] a_mask, b_mask;
   logic [15:0] a_cnt;
   logic [1:0]  b_cnt;

   writeback_regfile dut_a (
      .clk (clk), .reset (reset), .regWe (regWe), .dataToWrite (dataToWrite),
      .regToWrite (regToWrite), .ra1 (ra1), .ra2 (ra2), .rd1 (a_rd1), .rd2 (a_rd2),
      .wbDone (a_done), .writtenMask (a_mask), .writeCount (a_cnt)
   );

   writeback_regfile #(
      .ZERO_REG_EN (1'b1),
      .CNT_W       (2)
   ) dut_b (
      .clk (clk), .reset (reset), .regWe (regWe), .dataToWrite (dataToWrite),
      .regToWrite (regToWrite), .ra1 (ra1), .ra2 (ra2), .rd1 (b_rd1), .rd2 (b_rd2),
      .wbDone (b_done), .writtenMask (b_mask), .writeCount (b_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: index 0 models dut_a, index 1 models dut_b
   logic [23:0] m_regs [2][16];
   logic [15:0] m_mask [2];
   int          m_cnt  [2];
   logic        m_done [2];
   bit          m_zen  [2] = '{1'b0, 1'b1};
   int          m_cmax [2] = '{65535, 3};

   logic [23:0] p_a_rd1, p_a_rd2, p_b_rd1, p_b_rd2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit accepted(input int m);
      return regWe && !(m_zen[m] && regToWrite == 4'd0);
   endfunction

   function automatic logic [23:0] exp_rd(input int m, input logic [3:0] ra);
      if (m_zen[m] && ra == 4'd0) return 24'd0;
      if (accepted(m) && ra == regToWrite) return dataToWrite;
      return m_regs[m][ra];
   endfunction

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int r = 0; r < 16; r++) m_regs[m][r] = 24'd0;
            m_mask[m] = 16'd0;
            m_cnt[m]  = 0;
            m_done[m] = 1'b0;
         end else begin
            m_done[m] = accepted(m);
            if (accepted(m)) begin
               m_regs[m][regToWrite] = dataToWrite;
               m_mask[m][regToWrite] = 1'b1;
               if (m_cnt[m] < m_cmax[m]) m_cnt[m]++;
            end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic step(input logic rst, input logic we, input logic [23:0] d,
                       input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2,
                       input bit use_model);
      reset = rst; regWe = we; dataToWrite = d; regToWrite = wa; ra1 = r1; ra2 = r2;
      #1;
      p_a_rd1 = a_rd1; p_a_rd2 = a_rd2; p_b_rd1 = b_rd1; p_b_rd2 = b_rd2;
      if (use_model) begin
         chk("a_rd1", 32'(a_rd1), 32'(exp_rd(0, r1)));
         chk("a_rd2", 32'(a_rd2), 32'(exp_rd(0, r2)));
         chk("b_rd1", 32'(b_rd1), 32'(exp_rd(1, r1)));
         chk("b_rd2", 32'(b_rd2), 32'(exp_rd(1, r2)));
      end
      @(posedge clk);
      model_edge();
      #1;
      if (use_model) begin
         chk("a_wbDone", 32'(a_done), 32'(m_done[0]));
         chk("a_mask",   32'(a_mask), 32'(m_mask[0]));
         chk("a_count",  32'(a_cnt),  32'(m_cnt[0]));
         chk("b_wbDone", 32'(b_done), 32'(m_done[1]));
         chk("b_mask",   32'(b_mask), 32'(m_mask[1]));
         chk("b_count",  32'(b_cnt),  32'(m_cnt[1]));
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        rst;
      logic        we;
      logic [23:0] d;
      logic [3:0]  wa;
      logic [3:0]  r1;
      logic [3:0]  r2;
      bit          chk_rd;
      logic [23:0] e_rd1;
      logic [23:0] e_rd2;
      logic        e_done;
      logic [15:0] e_mask;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] rnd;
      logic [23:0] rd_data;
      logic [3:0]  rw, rr1, rr2;
      logic        rrst, rwe;

      reset = 1'b1; regWe = 1'b0; dataToWrite = '0; regToWrite = '0; ra1 = '0; ra2 = '0;

      // rst we  data        wa  r1  r2  chk  rd1         rd2         done mask      cnt
      tbl[0]  = '{1'b1, 1'b1, 24'hABCDEF, 4'd3, 4'd3, 4'd3, 1'b0, 24'h0,      24'h0,      1'b0, 16'h0000, 16'd0};
      tbl[1]  = '{1'b1, 1'b1, 24'hABCDEF, 4'd3, 4'd3, 4'd3, 1'b1, 24'hABCDEF, 24'hABCDEF, 1'b0, 16'h0000, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 24'h000000, 4'd0, 4'd3, 4'd5, 1'b1, 24'h0,      24'h0,      1'b0, 16'h0000, 16'd0};
      tbl[3]  = '{1'b0, 1'b1, 24'h123456, 4'd5, 4'd5, 4'd0, 1'b1, 24'h123456, 24'h0,      1'b1, 16'h0020, 16'd1};
      tbl[4]  = '{1'b0, 1'b0, 24'h000000, 4'd0, 4'd5, 4'd5, 1'b1, 24'h123456, 24'h123456, 1'b0, 16'h0020, 16'd1};
      tbl[5]  = '{1'b0, 1'b1, 24'h00FF00, 4'd7, 4'd7, 4'd7, 1'b1, 24'h00FF00, 24'h00FF00, 1'b1, 16'h00A0, 16'd2};
      tbl[6]  = '{1'b0, 1'b1, 24'h000001, 4'd2, 4'd2, 4'd7, 1'b1, 24'h000001, 24'h00FF00, 1'b1, 16'h00A4, 16'd3};
      tbl[7]  = '{1'b0, 1'b1, 24'h000002, 4'd2, 4'd2, 4'd5, 1'b1, 24'h000002, 24'h123456, 1'b1, 16'h00A4, 16'd4};
      tbl[8]  = '{1'b0, 1'b0, 24'h000000, 4'd0, 4'd2, 4'd7, 1'b1, 24'h000002, 24'h00FF00, 1'b0, 16'h00A4, 16'd4};
      tbl[9]  = '{1'b0, 1'b1, 24'hFFFFFF, 4'd0, 4'd0, 4'd1, 1'b1, 24'hFFFFFF, 24'h0,      1'b1, 16'h00A5, 16'd5};
      tbl[10] = '{1'b0, 1'b0, 24'h000000, 4'd0, 4'd0, 4'd3, 1'b1, 24'hFFFFFF, 24'h0,      1'b0, 16'h00A5, 16'd5};

      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].rst, tbl[i].we, tbl[i].d, tbl[i].wa, tbl[i].r1, tbl[i].r2, 1'b0);
         if (tbl[i].chk_rd) begin
            chk($sformatf("tbl%0d_rd1", i), 32'(p_a_rd1), 32'(tbl[i].e_rd1));
            chk($sformatf("tbl%0d_rd2", i), 32'(p_a_rd2), 32'(tbl[i].e_rd2));
         end
         chk($sformatf("tbl%0d_wbDone", i), 32'(a_done), 32'(tbl[i].e_done));
         chk($sformatf("tbl%0d_mask", i),   32'(a_mask), 32'(tbl[i].e_mask));
         chk($sformatf("tbl%0d_count", i),  32'(a_cnt),  32'(tbl[i].e_cnt));
      end

      // Hard-wired zero register on the ZERO_REG_EN instance
      step(1'b1, 1'b0, 24'h0, 4'd0, 4'd0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 24'hFFFFFF, 4'd0, 4'd0, 4'd0, 1'b0);
      chk("zero_rd1_bypass", 32'(p_b_rd1), 32'h0);
      chk("zero_wbDone",     32'(b_done),  32'h0);
      chk("zero_count",      32'(b_cnt),   32'h0);
      chk("zero_mask",       32'(b_mask),  32'h0);
      step(1'b0, 1'b0, 'x, 4'd0, 4'd0, 4'd0, 1'b0);
      chk("zero_rd1_after", 32'(p_b_rd1), 32'h0);
      chk("x_idle_count",   32'(b_cnt),   32'h0);

      // Counter saturation on the 2-bit instance, then a reset that drops a write
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 24'(i + 1), 4'd9, 4'd9, 4'd9, 1'b0);
         chk($sformatf("sat_count%0d", i), 32'(b_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      end
      step(1'b0, 1'b0, 24'h0, 4'd0, 4'd9, 4'd0, 1'b0);
      chk("sat_rd1_last", 32'(p_b_rd1), 32'd5);
      chk("sat_done_drop", 32'(b_done), 32'd0);
      step(1'b1, 1'b1, 24'h777777, 4'd9, 4'd9, 4'd9, 1'b0);
      chk("rst_count", 32'(b_cnt),  32'd0);
      chk("rst_mask",  32'(b_mask), 32'd0);
      chk("rst_done",  32'(b_done), 32'd0);
      step(1'b0, 1'b0, 24'h0, 4'd0, 4'd9, 4'd9, 1'b0);
      chk("rst_rd1_cleared", 32'(p_b_rd1), 32'd0);
      chk("rst_a_rd1_cleared", 32'(p_a_rd1), 32'd0);

      // Randomised traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rnd     = $urandom;
         rd_data = rnd[23:0];
         rnd     = $urandom;
         rw      = rnd[3:0];
         rr1     = (rnd[9:8] == 2'd0) ? rw : rnd[7:4];
         rr2     = (rnd[13:12] == 2'd0) ? rw : rnd[11:8];
         rwe     = rnd[16];
         rrst    = ($urandom_range(0, 49) == 0);
         if (rnd[20:18] == 3'd0) rw = 4'd0;
         step(rrst, rwe, rd_data, rw, rr1, rr2, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_writeback_regfile
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Final pipeline stage of the 24-bit processor.
- Consumes the memory stage's registered writeback bundle (reg write enable, 24-bit data, 4-bit destination) and commits it into a 16 x 24-bit architectural register file.
- Serves two combinational read ports to decode, with write-first bypass so decode sees a same-cycle writeback.
- Exposes a written-register mask, a commit pulse and a saturating commit counter for debug and verification.

Parameters:
- DATA_W, 24, register and data width.
- ADDR_W, 4, register index width.
- NUM_REGS, 16, number of architectural registers; equals 2**ADDR_W.
- ZERO_REG_EN, 0, when 1, register 0 ignores writes and always reads 0.
- CNT_W, 16, width of the commit counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- regWe  in  1  writeback enable from the memory-stage pipeline register.
- dataToWrite  in  DATA_W  writeback data (ALU result or load data) from the memory stage.
- regToWrite  in  ADDR_W  destination register index.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational).
- rd2  out  DATA_W  read data, port 2 (combinational).
- wbDone  out  1  registered pulse, high for one cycle after each accepted commit.
- writtenMask  out  NUM_REGS  bit i set once register i has been committed since reset.
- writeCount  out  CNT_W  number of accepted commits since reset, saturating.

Behaviour:
- Reset is synchronous and active-high, and wins over everything in the same edge.
  - All registers clear to 0.
  - wbDone, writtenMask and writeCount clear to 0.
  - A regWe asserted during the reset cycle is dropped, not committed.
- Commit: at a rising clk edge with reset=0 and regWe=1, regs[regToWrite] <= dataToWrite.
  - A commit is accepted unless ZERO_REG_EN=1 and regToWrite=0.
  - Commit latency is 1 cycle: the stored value is visible from the array starting in the next cycle.
- Read path is purely combinational, with no clock on it.
  - If regWe=1, the read address equals regToWrite, and the commit would be accepted: rdN = dataToWrite (write-first bypass).
  - Otherwise rdN = regs[raN].
  - If ZERO_REG_EN=1 and raN=0: rdN = 0, regardless of bypass.
  - Ports 1 and 2 are independent; both may bypass in the same cycle, or read the same register.
- Reads during reset: rd outputs follow the array contents, which are cleared at the reset edge.
  - Bypass remains active during reset, because the read path is combinational.
- wbDone: registered; equals 1 in cycle n+1 iff a commit was accepted at edge n.
  - Back-to-back commits hold wbDone high continuously.
- writtenMask: bit regToWrite sets on each accepted commit and never clears except on reset.
- writeCount: +1 per accepted commit.
  - Saturates at 2**CNT_W-1; no wrap-around.
- Repeated writes to the same register on consecutive cycles: last write wins; the bypass always reflects the current-cycle data.
- X on dataToWrite with regWe=0 must not alter state.

Decomposition:
- Shared package cpu_pkg holds DATA_W=24, ADDR_W=4 and NUM_REGS=16, plus the typedefs data_t (logic [23:0]) and reg_idx_t (logic [3:0]). The memory stage and decode also use this package.
- One natural sub-module: wb_bypass_mux, instantiated once per read port.
  - Inputs: array read value, raN, regWe, regToWrite, dataToWrite, zero-register enable.
  - Output: rdN.
- Counters, the mask and wbDone stay in the top level.

Test Plan:
- Reset values: hold reset for 2 cycles with regWe=1, regToWrite=3, dataToWrite=0xABCDEF -> after release: rd1 (ra1=3) = 0, writtenMask=0x0000, writeCount=0, wbDone=0.
- Basic commit: regWe=1, regToWrite=5, dataToWrite=0x123456 for 1 cycle, then regWe=0, ra1=5 -> rd1=0x123456; wbDone=1 for exactly one cycle; writtenMask=0x0020; writeCount=1.
- Bypass: same cycle regWe=1, regToWrite=7, dataToWrite=0x00FF00, ra1=7, ra2=7 -> rd1=rd2=0x00FF00 combinationally, before the edge.
- Back-to-back: write r2=0x000001, then r2=0x000002 on consecutive cycles, ra1=2 -> rd1 shows 1 then 2; wbDone high for 2 cycles; writeCount=2; writtenMask=0x0004.
- Zero register: with ZERO_REG_EN=1, regWe=1, regToWrite=0, dataToWrite=0xFFFFFF -> rd1 (ra1=0) = 0; wbDone=0; writeCount unchanged.
- Saturation and mid-run reset: with CNT_W=2, do 5 commits -> writeCount=3; then assert reset for one cycle while regWe=1 -> next cycle writeCount=0, writtenMask=0 and the target register reads 0.
